// File: rtl/contador_universal.sv
// -----------------------------------------------------------------------------
// contador_universal
//
// General-purpose up/down counter with a programmable modulus, a prescaler,
// a synchronous load, and either auto-reload or one-shot operation. It serves
// timers, clock dividers and display-scan sequencing.
//
// Ports
//   clk       in   rising-edge clock for all state
//   reset     in   asynchronous, active-low reset
//   en        in   count enable; low freezes both prescaler and counter
//   dir       in   0 = count up, 1 = count down
//   load      in   synchronous load strobe, highest synchronous priority
//   load_val  in   [N-1:0] value written to count on load
//   modulo    in   [N-1:0] terminal value; count range is 0..modulo
//   one_shot  in   0 = auto-reload, 1 = stop at the terminal value
//   prescale  in   [PRESCALE_W-1:0] a tick every prescale+1 enabled cycles
//   count     out  [N-1:0] current count
//   tc        out  registered one-cycle terminal-count pulse
//   done      out  sticky flag, set when a one-shot run finishes
// -----------------------------------------------------------------------------
module contador_universal #(
  parameter int N          = 4,
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  dir,
  input  logic                  load,
  input  logic [N-1:0]          load_val,
  input  logic [N-1:0]          modulo,
  input  logic                  one_shot,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [N-1:0]          count,
  output logic                  tc,
  output logic                  done
);

  typedef enum logic {RUN = 1'b0, STOP = 1'b1} state_t;

  localparam logic [N-1:0]          CNT_ONE = N'(1);
  localparam logic [PRESCALE_W-1:0] PRE_ONE = PRESCALE_W'(1);

  state_t                  state_q, state_d;
  logic [N-1:0]            count_q, count_d;
  logic                    tc_q, tc_d;
  logic                    done_q, done_d;
  logic [PRESCALE_W-1:0]   pre_cnt_q, pre_cnt_d;

  logic                    tick;
  logic                    terminal;
  logic                    run_tick;

  // Prescaler: a tick is an enabled cycle on which the divider reaches its
  // compare value. The divider keeps running in STOP; only the counter
  // ignores the resulting ticks.
  assign tick     = en && (pre_cnt_q == prescale);
  assign run_tick = tick && (state_q == RUN) && !load;

  // Up-count uses >= so a count loaded above modulo wraps back into range on
  // the next tick instead of running on through 2^N.
  assign terminal = dir ? (count_q == '0) : (count_q >= modulo);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values computed by the combinational blocks.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= RUN;
      count_q   <= '0;
      tc_q      <= 1'b0;
      done_q    <= 1'b0;
      pre_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      tc_q      <= tc_d;
      done_q    <= done_d;
      pre_cnt_q <= pre_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = RUN;
    end else if (run_tick && terminal && one_shot) begin
      state_d = STOP;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath / registered-output next values
  // ---------------------------------------------------------------------------
  always_comb begin
    count_d   = count_q;
    tc_d      = 1'b0;
    done_d    = done_q;
    pre_cnt_d = pre_cnt_q;

    // Prescaler divider
    if (load) begin
      pre_cnt_d = '0;
    end else if (en) begin
      pre_cnt_d = tick ? '0 : pre_cnt_q + PRE_ONE;
    end

    // Counter; load wins and discards any tick in the same cycle.
    if (load) begin
      count_d = load_val;
      done_d  = 1'b0;
    end else if (run_tick) begin
      if (terminal) begin
        tc_d = 1'b1;
        if (one_shot) begin
          done_d = 1'b1;             // count holds its terminal value
        end else begin
          count_d = dir ? modulo : '0;
        end
      end else begin
        count_d = dir ? count_q - CNT_ONE : count_q + CNT_ONE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: straight from the registers, no extra latency
  // ---------------------------------------------------------------------------
  always_comb begin
    count = count_q;
    tc    = tc_q;
    done  = done_q;
  end

endmodule

// File: tb/tb_contador_universal.sv
// -----------------------------------------------------------------------------
// tb_contador_universal
//
// Directed self-checking bench for contador_universal (N=4, PRESCALE_W=8).
// Inputs change 1 ns after a rising edge; outputs are sampled at that same
// point, so each check sees the result of the edge just taken.
// -----------------------------------------------------------------------------
module tb_contador_universal;

  localparam int N          = 4;
  localparam int PRESCALE_W = 8;

  logic                  clk;
  logic                  reset;
  logic                  en;
  logic                  dir;
  logic                  load;
  logic [N-1:0]          load_val;
  logic [N-1:0]          modulo;
  logic                  one_shot;
  logic [PRESCALE_W-1:0] prescale;
  logic [N-1:0]          count;
  logic                  tc;
  logic                  done;

  int tests_run = 0;
  int tests_failed = 0;

  contador_universal #(.N(N), .PRESCALE_W(PRESCALE_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .dir      (dir),
    .load     (load),
    .load_val (load_val),
    .modulo   (modulo),
    .one_shot (one_shot),
    .prescale (prescale),
    .count    (count),
    .tc       (tc),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic check_state(input string tag, input int exp_count,
                             input int exp_tc, input int exp_done);
    check({tag, ".count"}, 32'(count), 32'(exp_count));
    check({tag, ".tc"},    32'(tc),    32'(exp_tc));
    check({tag, ".done"},  32'(done),  32'(exp_done));
  endtask

  initial begin
    reset    = 1'b0;
    en       = 1'b0;
    dir      = 1'b0;
    load     = 1'b0;
    load_val = '0;
    modulo   = '0;
    one_shot = 1'b0;
    prescale = '0;

    // ---------------- Reset state ----------------
    #12;
    reset = 1'b1;
    check_state("reset", 0, 0, 0);

    // ---------------- Down count, modulo 9, prescale 0 ----------------
    en = 1'b1; dir = 1'b1; modulo = 4'd9; prescale = 8'd0; one_shot = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      int exp_c;
      step();
      exp_c = (20 - k) % 10;            // 9,8,...,0,9
      check_state($sformatf("down9[%0d]", k), exp_c, (exp_c == 9) ? 1 : 0, 0);
    end

    // ---------------- Up count, modulo 5, prescale 2 ----------------
    load = 1'b1; load_val = 4'd0; dir = 1'b0; modulo = 4'd5; prescale = 8'd2;
    step();
    load = 1'b0;
    check_state("up5.load", 0, 0, 0);
    for (int e = 1; e <= 18; e++) begin
      step();
      check_state($sformatf("up5[%0d]", e), (e / 3) % 6, (e == 18) ? 1 : 0, 0);
    end
    // en low for 4 cycles: everything freezes, tc drops
    en = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      step();
      check_state($sformatf("up5.hold[%0d]", e), 0, 0, 0);
    end
    en = 1'b1;
    for (int e = 1; e <= 18; e++) begin
      step();
      check_state($sformatf("up5.resume[%0d]", e), (e / 3) % 6,
                  (e == 18) ? 1 : 0, 0);
    end

    // ---------------- One-shot down from 3 ----------------
    one_shot = 1'b1; dir = 1'b1; prescale = 8'd0; modulo = 4'd9;
    load = 1'b1; load_val = 4'd3;
    step();
    load = 1'b0;
    check_state("os.load", 3, 0, 0);
    step(); check_state("os.2", 2, 0, 0);
    step(); check_state("os.1", 1, 0, 0);
    step(); check_state("os.0", 0, 0, 0);
    step(); check_state("os.term", 0, 1, 1);
    for (int t = 1; t <= 20; t++) begin
      step();
      check_state($sformatf("os.stop[%0d]", t), 0, 0, 1);
    end
    load = 1'b1; load_val = 4'd3;
    step();
    load = 1'b0;
    check_state("os.reload", 3, 0, 0);
    step(); check_state("os.rerun", 2, 0, 0);

    // ---------------- Load collides with a terminal tick ----------------
    one_shot = 1'b0; dir = 1'b1; modulo = 4'd9;
    load = 1'b1; load_val = 4'd0;
    step();
    check_state("coll.pre", 0, 0, 0);
    load_val = 4'd7;                    // next edge is terminal, load wins
    step();
    load = 1'b0;
    check_state("coll.load", 7, 0, 0);

    // ---------------- Out-of-range count ----------------
    dir = 1'b0; load = 1'b1; load_val = 4'd12;
    step();
    load = 1'b0;
    check_state("oor.up.load", 12, 0, 0);
    step();
    check_state("oor.up.wrap", 0, 1, 0);
    dir = 1'b1; load = 1'b1; load_val = 4'd12;
    step();
    load = 1'b0;
    check_state("oor.dn.load", 12, 0, 0);
    step(); check_state("oor.dn.11", 11, 0, 0);
    step(); check_state("oor.dn.10", 10, 0, 0);
    step(); check_state("oor.dn.9", 9, 0, 0);

    // ---------------- Asynchronous reset mid-count ----------------
    dir = 1'b0; modulo = 4'd9; prescale = 8'd2;
    load = 1'b1; load_val = 4'd0;
    step();
    load = 1'b0;
    for (int e = 1; e <= 19; e++) step();   // count=6, pre_cnt=1
    check_state("ar.before", 6, 0, 0);
    #2;
    reset = 1'b0;
    #1;
    check_state("ar.async", 0, 0, 0);
    #1;
    reset = 1'b1;
    step(); check_state("ar.resume1", 0, 0, 0);
    step(); check_state("ar.resume2", 0, 0, 0);
    step(); check_state("ar.resume3", 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/contador_universal.md
Name: contador_universal

Overview:
Parametrised up/down counter. It has a programmable modulus, a prescaler, synchronous load, and auto-reload or one-shot mode. It is the general-purpose successor to the fixed down-counter and serves timers, dividers and display-scan sequencing in the lab designs. The count, a registered terminal-count pulse and a sticky done flag drive downstream logic directly.

Parameters:
N, 4, counter width in bits
PRESCALE_W, 8, prescaler compare width in bits

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset
en  input  1  count enable; when low, the prescaler and counter freeze
dir  input  1  0 = count up, 1 = count down
load  input  1  synchronous load strobe; highest synchronous priority
load_val  input  N  value written to count on load
modulo  input  N  terminal value; count range is 0..modulo
one_shot  input  1  0 = auto-reload, 1 = stop at terminal
prescale  input  PRESCALE_W  a tick occurs every prescale+1 enabled cycles
count  output  N  current count
tc  output  1  one-cycle terminal-count pulse, registered
done  output  1  sticky; set when a one-shot run finishes

Behaviour:
- Reset (asynchronous, active-low):
  - count=0, tc=0, done=0, prescaler counter=0, state=RUN.
  - Reset applies immediately, even mid-run, and dominates load/en.
- States:
  - RUN: counting.
  - STOP: one-shot finished. Ticks are ignored, count holds, tc stays 0.
  - Only load leaves STOP.
- Prescaler:
  - Internal pre_cnt is PRESCALE_W bits.
  - When en=1: if pre_cnt==prescale, tick=1 and pre_cnt<=0; otherwise pre_cnt<=pre_cnt+1.
  - When en=0: pre_cnt holds and tick=0.
  - prescale=0 gives a tick on every enabled cycle.
- Load (priority 1, independent of en):
  - count<=load_val, pre_cnt<=0, state<=RUN, done<=0, tc<=0.
  - A tick in the same cycle is discarded.
- Tick in RUN, dir=1 (down):
  - count==0 is terminal.
  - Otherwise count<=count-1.
  - A count above modulo (loaded out of range) still decrements normally.
- Tick in RUN, dir=0 (up):
  - count>=modulo is terminal; >= so that an out-of-range count recovers.
  - Otherwise count<=count+1.
- Terminal tick, auto-reload (one_shot=0):
  - Count wraps: down to modulo, up to 0.
  - tc=1 for exactly the next cycle, coincident with the wrapped count.
- Terminal tick, one-shot (one_shot=1):
  - Count holds its terminal value, tc=1 for one cycle, done<=1, state<=STOP.
- tc: high for a single cycle per terminal event. With prescale=0 and modulo=0 it may be high on consecutive cycles (auto-reload).
- Live inputs: dir, modulo, one_shot and prescale are sampled live. A change takes effect on the next tick; no pipeline delay.
- modulo=0: every tick is terminal and count stays 0.
- Widths: all count arithmetic is modulo 2^N; no overflow flag. pre_cnt compare is an unsigned equality.
- Latency: count and tc update on the clock edge where the tick is taken; no extra registers in the path.

Test Plan:
- Reset then en=1, dir=1, modulo=9, prescale=0, one_shot=0 -> count 0,9,8,...,0,9. tc high exactly on the cycles count returns to 9; 10-cycle period.
- dir=0, modulo=5, prescale=2, en=1 -> count advances every 3rd cycle: 0,1,...,5,0. tc once per 18 cycles. Dropping en for 4 cycles stretches the period by exactly 4.
- one_shot=1, dir=1, load_val=3 with load pulse -> 3,2,1,0, then tc pulse and done=1. count stays 0 for 20 further ticks with tc=0. A second load restarts the run and clears done.
- load asserted on the same edge as a terminal tick with load_val=7 -> count=7, tc=0, no wrap.
- Load count=12 with modulo=9, dir=0 -> next tick gives count=0 and tc=1. With dir=1 instead, count=11, then 10, ...
- Async reset driven low mid-count (count=6, pre_cnt≠0) between clock edges -> count=0, tc=0, done=0 immediately. Counting resumes from 0 after reset releases.
